// File: rtl/select_n_1_reg_wn_if.sv
// Flow-controlled N-way select bus.
// Producer side: in_valid, in_ready, i_data (nsel lanes of dwidth), enable (one-hot).
// Consumer side: out_valid, out_ready, o0 (selected data), o_idx (lane index), o_err.
// master = the environment (producer + consumer), slave = the select block.
interface select_n_1_reg_wn_if #(
  parameter int dwidth = 32,
  parameter int nsel   = 4
);
  localparam int iw = $clog2(nsel);

  logic                   in_valid;
  logic                   in_ready;
  logic [nsel*dwidth-1:0] i_data;
  logic [nsel-1:0]        enable;
  logic                   out_valid;
  logic                   out_ready;
  logic [dwidth-1:0]      o0;
  logic [iw-1:0]          o_idx;
  logic                   o_err;

  modport master (
    output in_valid, i_data, enable, out_ready,
    input  in_ready, out_valid, o0, o_idx, o_err
  );

  modport slave (
    input  in_valid, i_data, enable, out_ready,
    output in_ready, out_valid, o0, o_idx, o_err
  );
endinterface

// File: rtl/select_n_1_reg_wn.sv
// N-way one-hot select with a registered, valid/ready flow-controlled output.
// The selected lane, its index and an illegal-enable flag are captured on each
// accepted beat and held until the consumer takes them. Illegal beats (several
// enable bits set, or none when zero_on_none=0) deliver zero data with o_err=1
// and bump a saturating error counter.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      select_n_1_reg_wn_if.slave (handshake, lanes, enable, outputs)
//   err_cnt  saturating count of illegal beats
//   err_clr  synchronous clear of err_cnt
module select_n_1_reg_wn #(
  parameter int dwidth       = 32,
  parameter int nsel         = 4,
  parameter bit zero_on_none = 1'b1,
  parameter int cntw         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  select_n_1_reg_wn_if.slave     bus,
  output logic [cntw-1:0]        err_cnt,
  input  logic                   err_clr
);
  localparam int iw = $clog2(nsel);
  localparam logic [cntw-1:0] cnt_max = {cntw{1'b1}};

  logic              accept;
  logic              any_set;
  logic              multi_set;
  logic              illegal;
  logic [iw-1:0]     hit_idx;
  logic [dwidth-1:0] hit_data;
  logic [iw-1:0]     dec_idx;
  logic [dwidth-1:0] dec_data;

  // A full register may still accept when the held beat leaves this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    any_set   = 1'b0;
    multi_set = 1'b0;
    hit_idx   = '0;
    hit_data  = '0;
    for (int k = 0; k < nsel; k++) begin
      if (bus.enable[k]) begin
        if (any_set) multi_set = 1'b1;
        any_set  = 1'b1;
        hit_idx  = iw'(k);
        hit_data = bus.i_data[k*dwidth +: dwidth];
      end
    end
    illegal  = multi_set || (!any_set && !zero_on_none);
    // Only a clean one-hot pick forwards lane data; everything else is zero.
    dec_idx  = (any_set && !multi_set) ? hit_idx  : '0;
    dec_data = (any_set && !multi_set) ? hit_data : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.o0        <= '0;
      bus.o_idx     <= '0;
      bus.o_err     <= 1'b0;
    end else begin
      // EMPTY/FULL tracked by out_valid: load on accept, drain on deliver.
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.o0        <= dec_data;
        bus.o_idx     <= dec_idx;
        bus.o_err     <= illegal;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      // A clear coinciding with an illegal beat still records that beat.
      err_cnt <= (accept && illegal) ? cntw'(1) : '0;
    end else if (accept && illegal && err_cnt != cnt_max) begin
      err_cnt <= err_cnt + cntw'(1);
    end
  end
endmodule
